// File: rtl/int_arbiter.sv
// int_arbiter: eight-source level interrupt gateway with priority arbitration,
// a claim/complete handshake and a small memory-mapped register file.
// Ports keep the names used by the core integration (clk, rst, *_i, *_o).

module int_arbiter #(
    parameter int NUM_SRC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq_src_i,
    input  logic        bus_we_i,
    input  logic        bus_re_i,
    input  logic [7:0]  bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic [31:0] int_req_o,
    output logic [3:0]  int_id_o
);

    localparam logic [7:0] ADDR_PENDING = 8'h00;
    localparam logic [7:0] ADDR_ENABLE  = 8'h04;
    localparam logic [7:0] ADDR_THRESH  = 8'h08;
    localparam logic [7:0] ADDR_CLAIM   = 8'h0C;
    localparam logic [7:0] ADDR_PRIO    = 8'h10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ARB     = 4'b0010,
        ST_NOTIFY  = 4'b0100,
        ST_SERVICE = 4'b1000
    } state_t;

    state_t      r_state;
    logic [3:0]  r_curId;
    logic [7:0]  r_pending;
    logic [7:0]  r_inService;
    logic [7:0]  r_enable;
    logic [2:0]  r_threshold;
    logic [2:0]  r_prio [NUM_SRC];
    logic [7:0]  r_irqPrev;
    logic        r_gateArm;

    logic [7:0]  w_rise;
    logic [7:0]  w_eligible;
    logic        w_anyEligible;
    logic [2:0]  w_winIdx;
    logic [2:0]  w_bestPrio;
    logic        w_found;
    logic [3:0]  w_winId;
    logic [2:0]  w_curIdx;
    logic [7:0]  w_curMask;
    logic        w_claimRead;
    logic        w_completeHit;
    logic [31:0] w_prioWord;
    logic [31:0] w_readMux;
    logic        w_unusedBits;

    assign w_claimRead   = bus_re_i && (bus_addr_i == ADDR_CLAIM) && (r_state == ST_NOTIFY);
    assign w_completeHit = bus_we_i && (bus_addr_i == ADDR_CLAIM) && (r_state == ST_SERVICE)
                           && (bus_wdata_i[3:0] == r_curId);
    assign w_curIdx      = r_curId[2:0] - 3'd1;
    assign w_curMask     = 8'b1 << w_curIdx;
    assign w_winId       = {1'b0, w_winIdx} + 4'd1;
    assign w_anyEligible = |w_eligible;
    assign w_unusedBits  = ^{bus_wdata_i, r_curId[3]};

    // The first cycle after reset only loads the edge-detect copies, so a source
    // already high while reset was asserted is not mistaken for a new rising edge.
    assign w_rise = irq_src_i & ~r_irqPrev & ~r_inService & {8{r_gateArm}};

    // A source may interrupt only when pending, enabled and strictly above threshold.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_eligible[i] = r_pending[i] & r_enable[i] & (r_prio[i] > r_threshold);
        end
    end

    // Highest priority wins; the strict compare keeps the lowest index on ties.
    always_comb begin
        w_winIdx   = '0;
        w_bestPrio = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_eligible[i] && (!w_found || (r_prio[i] > w_bestPrio))) begin
                w_found    = 1'b1;
                w_bestPrio = r_prio[i];
                w_winIdx   = 3'(i);
            end
        end
    end

    // Pack the per-source priority fields into their register image, gaps read as zero.
    always_comb begin
        w_prioWord = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_prioWord[4*i +: 3] = r_prio[i];
        end
    end

    // Select read data; a claim read only returns an id while a request is being offered.
    always_comb begin
        w_readMux = '0;
        case (bus_addr_i)
            ADDR_PENDING: w_readMux = {24'h0, r_pending};
            ADDR_ENABLE:  w_readMux = {24'h0, r_enable};
            ADDR_THRESH:  w_readMux = {29'h0, r_threshold};
            ADDR_CLAIM:   w_readMux = w_claimRead ? {28'h0, r_curId} : 32'h0;
            ADDR_PRIO:    w_readMux = w_prioWord;
            default:      w_readMux = '0;
        endcase
    end

    // Gateway: edge-detect sources into pending; a claim clears pending ahead of any same-cycle edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irqPrev   <= '0;
            r_gateArm   <= 1'b0;
            r_pending   <= '0;
            r_inService <= '0;
        end else begin
            r_irqPrev   <= irq_src_i;
            r_gateArm   <= 1'b1;
            r_pending   <= (r_pending | w_rise) & ~(w_claimRead ? w_curMask : 8'h00);
            r_inService <= (r_inService | (w_claimRead ? w_curMask : 8'h00))
                           & ~(w_completeHit ? w_curMask : 8'h00);
        end
    end

    // Software-writable configuration: enable mask, threshold and per-source priorities.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable    <= '0;
            r_threshold <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_prio[i] <= '0;
            end
        end else if (bus_we_i) begin
            if (bus_addr_i == ADDR_ENABLE) begin
                r_enable <= bus_wdata_i[7:0];
            end
            if (bus_addr_i == ADDR_THRESH) begin
                r_threshold <= bus_wdata_i[2:0];
            end
            if (bus_addr_i == ADDR_PRIO) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    r_prio[i] <= bus_wdata_i[4*i +: 3];
                end
            end
        end
    end

    // Read data is captured one cycle after the strobe and otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata_o <= '0;
        end else if (bus_re_i) begin
            bus_rdata_o <= w_readMux;
        end
    end

    // Arbitration FSM with registered request/id outputs; an offered request is never pre-empted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_curId   <= '0;
            int_req_o <= '0;
            int_id_o  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    int_req_o <= '0;
                    int_id_o  <= '0;
                    if (w_anyEligible) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (w_anyEligible) begin
                        r_curId   <= w_winId;
                        r_state   <= ST_NOTIFY;
                        int_req_o <= 32'h0000_0001;
                        int_id_o  <= w_winId;
                    end else begin
                        r_state   <= ST_IDLE;
                        int_req_o <= '0;
                        int_id_o  <= '0;
                    end
                end
                ST_NOTIFY: begin
                    if (w_claimRead) begin
                        r_state   <= ST_SERVICE;
                        int_req_o <= '0;
                        int_id_o  <= r_curId;
                    end else if (!w_eligible[w_curIdx]) begin
                        r_state   <= ST_IDLE;
                        int_req_o <= '0;
                        int_id_o  <= '0;
                    end
                end
                ST_SERVICE: begin
                    int_req_o <= '0;
                    if (w_completeHit) begin
                        r_state  <= ST_IDLE;
                        int_id_o <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    int_req_o <= '0;
                    int_id_o  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed, table-driven bench for int_arbiter. Inputs are
// driven and outputs sampled on the falling clock edge.

module tb_int_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src_i;
    logic        bus_we_i;
    logic        bus_re_i;
    logic [7:0]  bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic [31:0] bus_rdata_o;
    logic [31:0] int_req_o;
    logic [3:0]  int_id_o;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        bit          isWrite;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    int_arbiter #(.NUM_SRC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src_i  (irq_src_i),
        .bus_we_i   (bus_we_i),
        .bus_re_i   (bus_re_i),
        .bus_addr_i (bus_addr_i),
        .bus_wdata_i(bus_wdata_i),
        .bus_rdata_o(bus_rdata_o),
        .int_req_o  (int_req_o),
        .int_id_o   (int_id_o)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus cycle, issued at a falling edge; read data is valid on return.
    task automatic applyStimulus(input bit isWrite, input logic [7:0] addr, input logic [31:0] wdata);
        bus_we_i    = isWrite;
        bus_re_i    = !isWrite;
        bus_addr_i  = addr;
        bus_wdata_i = wdata;
        @(negedge clk);
        bus_we_i    = 1'b0;
        bus_re_i    = 1'b0;
        bus_wdata_i = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus_we_i = 1'b0;
        bus_re_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseIrq(input logic [7:0] mask);
        irq_src_i = irq_src_i | mask;
        @(negedge clk);
        irq_src_i = irq_src_i & ~mask;
    endtask

    task automatic waitReq(input int maxCycles, input string name);
        int n = 0;
        while (int_req_o !== 32'h1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int_req_o, 32'h1);
    endtask

    task automatic claimExpect(input logic [3:0] id, input string name);
        applyStimulus(1'b0, 8'h0C, 32'h0);
        checkOutput({name, " claim id"}, bus_rdata_o, {28'h0, id});
        checkOutput({name, " req low after claim"}, int_req_o, 32'h0);
    endtask

    task automatic configure(input logic [7:0] en, input logic [31:0] prio, input logic [2:0] thr);
        applyStimulus(1'b1, 8'h04, {24'h0, en});
        applyStimulus(1'b1, 8'h10, prio);
        applyStimulus(1'b1, 8'h08, {29'h0, thr});
    endtask

    initial begin
        irq_src_i   = '0;
        bus_we_i    = 1'b0;
        bus_re_i    = 1'b0;
        bus_addr_i  = '0;
        bus_wdata_i = '0;
        rst         = 1'b1;
        doReset();

        checkOutput("reset int_req", int_req_o, 32'h0);
        checkOutput("reset int_id", {28'h0, int_id_o}, 32'h0);
        checkOutput("reset rdata", bus_rdata_o, 32'h0);

        // Register map vectors (no interrupts active).
        vecs.push_back('{1'b0, 8'h00, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h04, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 8'h04, 32'hFFFF_FFAA, 32'h0});
        vecs.push_back('{1'b0, 8'h04, 32'h0,        32'h0000_00AA});
        vecs.push_back('{1'b1, 8'h08, 32'hFFFF_FFFD, 32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0,        32'h0000_0005});
        vecs.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0,        32'h7777_7777});
        vecs.push_back('{1'b1, 8'h10, 32'h1234_5678, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0,        32'h1234_5670});
        vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 8'h20, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h05, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 8'h04, 32'h0,        32'h0000_00AA});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].isWrite) begin
                checkOutput($sformatf("vec%0d read 0x%02h", i, vecs[i].addr), bus_rdata_o, vecs[i].expRdata);
            end
        end
        tick(3);
        checkOutput("rdata holds", bus_rdata_o, 32'h0000_00AA);

        // Basic latency and claim/complete on source 0.
        doReset();
        configure(8'h01, 32'h0000_0003, 3'd0);
        pulseIrq(8'h01);
        checkOutput("lat cycle1 req", int_req_o, 32'h0);
        tick(1);
        checkOutput("lat cycle2 req", int_req_o, 32'h0);
        tick(1);
        checkOutput("lat cycle3 req", int_req_o, 32'h1);
        checkOutput("lat cycle3 id", {28'h0, int_id_o}, 32'h1);
        claimExpect(4'd1, "basic");
        checkOutput("service id", {28'h0, int_id_o}, 32'h1);
        applyStimulus(1'b1, 8'h0C, 32'h1);
        checkOutput("complete id clears", {28'h0, int_id_o}, 32'h0);

        // Priority: sources 1 and 2 together, 2 has higher priority.
        doReset();
        configure(8'h06, 32'h0000_0650, 3'd0);
        pulseIrq(8'h06);
        waitReq(6, "prio first req");
        claimExpect(4'd3, "prio first");
        applyStimulus(1'b1, 8'h0C, 32'h3);
        waitReq(6, "prio second req");
        claimExpect(4'd2, "prio second");
        applyStimulus(1'b1, 8'h0C, 32'h2);

        // Tie on equal priority: lowest index first.
        doReset();
        configure(8'h81, 32'h4000_0004, 3'd0);
        pulseIrq(8'h81);
        waitReq(6, "tie first req");
        claimExpect(4'd1, "tie first");
        applyStimulus(1'b1, 8'h0C, 32'h1);
        waitReq(6, "tie second req");
        claimExpect(4'd8, "tie second");
        applyStimulus(1'b1, 8'h0C, 32'h8);

        // Threshold masking, then withdrawal of eligibility while notifying.
        doReset();
        configure(8'h01, 32'h0000_0002, 3'd2);
        pulseIrq(8'h01);
        tick(4);
        checkOutput("thresh blocks req", int_req_o, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("thresh pending set", bus_rdata_o, 32'h1);
        applyStimulus(1'b1, 8'h08, 32'h1);
        waitReq(6, "thresh lowered req");
        checkOutput("thresh lowered id", {28'h0, int_id_o}, 32'h1);
        applyStimulus(1'b1, 8'h04, 32'h0);
        tick(1);
        checkOutput("disable drops req", int_req_o, 32'h0);
        checkOutput("disable drops id", {28'h0, int_id_o}, 32'h0);
        applyStimulus(1'b1, 8'h04, 32'h1);
        waitReq(6, "re-enable req");
        claimExpect(4'd1, "re-enable");
        applyStimulus(1'b1, 8'h0C, 32'h1);

        // No pre-emption of an offered request.
        doReset();
        configure(8'h03, 32'h0000_0072, 3'd0);
        pulseIrq(8'h01);
        waitReq(6, "preempt first req");
        pulseIrq(8'h02);
        tick(2);
        checkOutput("no preempt id", {28'h0, int_id_o}, 32'h1);
        claimExpect(4'd1, "no preempt");
        applyStimulus(1'b1, 8'h0C, 32'h1);
        waitReq(6, "preempt later req");
        claimExpect(4'd2, "preempt later");
        applyStimulus(1'b1, 8'h0C, 32'h2);

        // Mismatched complete and edges during service.
        doReset();
        configure(8'h01, 32'h0000_0003, 3'd0);
        pulseIrq(8'h01);
        waitReq(6, "svc req");
        claimExpect(4'd1, "svc");
        applyStimulus(1'b1, 8'h0C, 32'h5);
        checkOutput("bad complete id kept", {28'h0, int_id_o}, 32'h1);
        checkOutput("bad complete req", int_req_o, 32'h0);
        pulseIrq(8'h01);
        tick(2);
        checkOutput("svc still id", {28'h0, int_id_o}, 32'h1);
        applyStimulus(1'b1, 8'h0C, 32'h1);
        tick(4);
        checkOutput("svc edge dropped req", int_req_o, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("svc edge dropped pending", bus_rdata_o, 32'h0);

        // Edge on claimed source in the claim cycle is dropped; other source latches.
        doReset();
        configure(8'h03, 32'h0000_0033, 3'd0);
        pulseIrq(8'h01);
        waitReq(6, "race req");
        irq_src_i = 8'h03;
        applyStimulus(1'b0, 8'h0C, 32'h0);
        irq_src_i = 8'h00;
        checkOutput("race claim id", bus_rdata_o, 32'h1);
        applyStimulus(1'b1, 8'h0C, 32'h1);
        waitReq(6, "race other req");
        claimExpect(4'd2, "race other");
        applyStimulus(1'b1, 8'h0C, 32'h2);
        tick(4);
        checkOutput("race dropped req", int_req_o, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("race dropped pending", bus_rdata_o, 32'h0);

        // Reset while notifying abandons the transaction.
        doReset();
        configure(8'h01, 32'h0000_0003, 3'd0);
        pulseIrq(8'h01);
        waitReq(6, "rst notify req");
        doReset();
        checkOutput("rst notify req", int_req_o, 32'h0);
        checkOutput("rst notify id", {28'h0, int_id_o}, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("rst notify pending", bus_rdata_o, 32'h0);
        applyStimulus(1'b0, 8'h04, 32'h0);
        checkOutput("rst notify enable", bus_rdata_o, 32'h0);

        // Source held high through reset makes no request until it rises again.
        irq_src_i = 8'h01;
        doReset();
        configure(8'h01, 32'h0000_0003, 3'd0);
        tick(4);
        checkOutput("held high req", int_req_o, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("held high pending", bus_rdata_o, 32'h0);
        irq_src_i = 8'h00;
        tick(1);
        pulseIrq(8'h01);
        waitReq(6, "held new edge req");
        claimExpect(4'd1, "held new edge");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of external interrupt sources (fixed 8 for this revision).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port irq_src_i  input  8  level interrupt sources; bit i = source id i+1.
REQ-005 SHALL have port bus_we_i  input  1  register write strobe, one cycle per write.
REQ-006 SHALL have port bus_re_i  input  1  register read strobe, one cycle per read.
REQ-007 SHALL have port bus_addr_i  input  8  byte address of register.
REQ-008 SHALL have port bus_wdata_i  input  32  write data.
REQ-009 SHALL have port bus_rdata_o  output  32  registered read data.
REQ-010 SHALL have port int_req_o  output  32  interrupt request to core interrupt controller; 32'h0 = no interrupt.
REQ-011 SHALL have port int_id_o  output  4  id of current request/in-service source; 0 = none.

Function
REQ-012 Register map: 0x00 pending RO [7:0]; 0x04 enable RW [7:0]; 0x08 threshold RW [2:0]; 0x0C claim (read)/complete (write); 0x10 priority RW, 3-bit field per source at bits [4i+2:4i], bit 4i+3 reads 0.
REQ-013 Reads SHALL return data on bus_rdata_o exactly one cycle after bus_re_i; unmapped address reads 0; bus_rdata_o holds last value otherwise.
REQ-014 Writes to 0x00 and unmapped addresses SHALL be ignored; unused bits write-ignored, read 0.
REQ-015 Gateway: pending[i] SHALL set on a rising edge of irq_src_i[i] (compared with 1-cycle registered copy) only when in_service[i]=0; edges while in service are dropped.
REQ-016 eligible[i] = pending[i] & enable[i] & (prio[i] > threshold); priority 0 never interrupts.
REQ-017 Winner = eligible source with highest priority; tie broken by lowest index.
REQ-018 FSM states IDLE, ARB, NOTIFY, SERVICE; one-hot encoded.
REQ-019 IDLE: any eligible -> ARB next cycle; else stay.
REQ-020 ARB: latch winner into cur_id (id = index+1) -> NOTIFY; if no eligible remains -> IDLE.
REQ-021 NOTIFY: int_req_o = 32'h0000_0001, int_id_o = cur_id; if source cur_id becomes ineligible (enable/priority/threshold change) -> IDLE without claim.
REQ-022 Claim read in NOTIFY SHALL return cur_id, clear pending[cur_id-1], set in_service, -> SERVICE; claim read in any other state returns 0 with no side effect.
REQ-023 SERVICE: int_req_o = 0, int_id_o = cur_id; write to 0x0C with wdata[3:0] = cur_id clears in_service -> IDLE; mismatched id ignored, stay.
REQ-024 A higher-priority eligible source arriving in NOTIFY SHALL NOT pre-empt; it is taken after return to IDLE.
REQ-025 Rising edge on claimed source in same cycle as claim: claim wins, edge dropped; edges on other sources latch regardless of FSM state.
REQ-026 Register write and gateway set of the same pending bit in the same cycle cannot conflict (pending RO).
REQ-027 Minimum latency: rising edge at cycle N -> pending at N+1 -> ARB N+2 -> int_req_o asserted N+3.

Reset
REQ-028 rst high at clock edge SHALL clear pending, in_service, enable, threshold, priorities, edge-detect copies, cur_id, bus_rdata_o, int_req_o, int_id_o; FSM -> IDLE.
REQ-029 Reset mid-NOTIFY or mid-SERVICE SHALL abandon the transaction; sources held high after reset SHALL NOT generate pending until a new rising edge.

Verification
REQ-030 enable=0x01, prio src0=3, threshold=0, pulse irq_src_i[0] -> int_req_o=32'h1 three cycles later, claim reads 1, int_req_o=0 next cycle.
REQ-031 srcs 1 and 2 prio 5 and 6, both edges same cycle -> claim returns 3; complete 3 -> claim later returns 2.
REQ-032 equal prio 4 on srcs 0 and 7 -> claim returns 1 first, then 8.
REQ-033 prio src0=2, threshold=2, edge -> int_req_o stays 0; threshold=1 -> int_req_o asserts.
REQ-034 in SERVICE, complete with id 5 when cur_id=1 -> ignored, int_id_o stays 1; new edge on src0 dropped.
REQ-035 rst asserted in NOTIFY -> next cycle int_req_o=0, pending=0, read 0x04 returns 0.
